bambu_offchip_mem_slave: RTL and testbench
==========================================

# bambu_offchip_mem_slave

Parametrised multi-channel off-chip memory slave for HLS co-simulation and on-board test harnesses. Serves N_CH independent master channels, each driving the oe/we/addr/wdata/size ram bus of an HLS top, with its own configurable read and write latency, bit-granular write masking and a DataRdy handshake. Sits outside the accelerator top and answers only inside a base-address window, so it can share the bus with other slaves whose responses are OR-ed in.

## Interface
- N_CH, 2: number of independent master channels.
- ADDR_W, 7: per-channel address width; addresses are word indices.
- DATA_W, 8: per-channel data width in bits; must be a multiple of 8.
- SIZE_W, 4: per-channel size field width; holds 0..DATA_W.
- MEM_WORDS, 32: number of DATA_W-bit words stored.
- RD_LAT, 2: read latency in cycles, 1..15.
- WR_LAT, 1: write latency in cycles, 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- base_addr  in  ADDR_W  first word address served; window is base_addr..base_addr+MEM_WORDS-1.
- oe  in  N_CH  per-channel read request.
- we  in  N_CH  per-channel write request.
- addr  in  N_CH*ADDR_W  per-channel address; channel i occupies slice i.
- wdata  in  N_CH*DATA_W  per-channel write data.
- size  in  N_CH*SIZE_W  per-channel access size in bits.
- load_en  in  1  preload strobe.
- load_addr  in  ADDR_W  preload word index, relative to base_addr.
- load_data  in  DATA_W  preload word.
- rdata  out  N_CH*DATA_W  per-channel read data; zero when that channel's rdy is low.
- rdy  out  N_CH  per-channel DataRdy.
- err  out  N_CH  sticky per-channel protocol error.

## Operation
- A request on channel i is "hit" when oe[i]^we[i] is true and the address lies in the window. Out-of-window requests get no response: rdy 0, rdata 0, counter 0.
- Each channel has a latency counter cnt[i], 4 bits. While a hit is held, cnt increments every edge. When it reaches LAT-1 (LAT = RD_LAT for a read, WR_LAT for a write), rdy[i] is asserted combinationally. cnt returns to 0 on the following edge.
- With LAT = 1, rdy is asserted in the first request cycle.
- The master holds oe/we/addr/wdata/size stable until it sees rdy. If a request is dropped early, cnt goes to 0 on the next edge and nothing is written.
- Read data: in the rdy cycle, rdata[i] = mem[addr-base_addr] & mask. mask = (1<<size)-1, and size >= DATA_W gives all ones. Reads see every write committed at earlier edges.
- Write commit: on the edge where rdy[i]=1, mem = (wdata & mask) | (mem & ~mask). size = 0 completes the handshake but changes nothing.
- Same-word writes committing on the same edge: the highest channel index wins. load_en beats every channel write.
- Preload: on any edge with load_en=1 and load_addr < MEM_WORDS, mem[load_addr] = load_data. Out-of-range loads are ignored.
- err[i] is set on the edge where oe[i] and we[i] are both 1. It is also set on a hit whose addr, wdata or size changes while cnt != 0. err[i] stays set until reset.
- Channels are fully independent. Reads and writes on different channels may overlap freely.

## Timing
- Reset (reset=0, asynchronous): cnt=0, err=0, and rdy=0 and rdata=0 immediately. Memory contents are not cleared. A mid-transaction reset abandons that transaction with no write, and the master must re-issue it.
- Read latency: the request is presented in cycle 0 and rdy/rdata are valid in cycle RD_LAT-1. Back-to-back reads cost RD_LAT cycles each, since cnt restarts at 0 after the rdy edge.
- Write latency: rdy in cycle WR_LAT-1, commit at the end of that cycle. A read of the same word on another channel sees the new value from the next cycle on.
- Window compare is unsigned on ADDR_W bits. base_addr+MEM_WORDS wrap-around is not supported: the window must not cross 2^ADDR_W.
- base_addr must stay constant while any cnt != 0.

## Test plan
- Reset, then preload word 3 = 0xA5 with base_addr=0x10. Read ch0 at 0x13 with RD_LAT=2, size=8: rdy high in cycle 1 only, rdata=0xA5, rdy low in cycle 2.
- Masked write: ch1 writes 0xFF at 0x13 with size=4 and WR_LAT=1, so rdy is high in cycle 0. A following read returns 0xAF.
- Collision: ch0 writes 0x11 and ch1 writes 0x22 to 0x14, committing on the same edge. Read-back gives 0x22. Repeat with load_en=1, load_data=0x33 on that edge: read-back gives 0x33.
- Out of window: ch0 reads 0x30 with MEM_WORDS=32 and base 0x10. rdy stays 0 for 20 cycles, rdata=0, err=0.
- Protocol errors: oe[0]=we[0]=1 for one cycle sets err[0]=1 while err[1] stays 0. Changing addr mid-read on ch1 sets err[1]=1. Both clear only on reset.
- Reset mid-write: WR_LAT=3, reset asserted in cycle 1. No commit happens, the old word value is retained, and cnt=0, rdy=0.

Source files
------------

// File: rtl/bambu_offchip_mem_slave.sv
// Multi-channel off-chip memory slave for HLS ram buses: windowed address decode,
// per-channel latency counters, bit-masked writes and sticky protocol-error flags.
module bambu_offchip_mem_slave #(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SIZE_W    = 4,
  parameter int unsigned MEM_WORDS = 32,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned WR_LAT    = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [N_CH-1:0]        oe,
  input  logic [N_CH-1:0]        we,
  input  logic [N_CH*ADDR_W-1:0] addr,
  input  logic [N_CH*DATA_W-1:0] wdata,
  input  logic [N_CH*SIZE_W-1:0] size,
  input  logic                   load_en,
  input  logic [ADDR_W-1:0]      load_addr,
  input  logic [DATA_W-1:0]      load_data,
  output logic [N_CH*DATA_W-1:0] rdata,
  output logic [N_CH-1:0]        rdy,
  output logic [N_CH-1:0]        err
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_LAT - 1);

  logic [DATA_W-1:0] mem       [MEM_WORDS];
  logic [CNT_W-1:0]  cnt       [N_CH];
  logic [ADDR_W-1:0] prev_addr [N_CH];
  logic [DATA_W-1:0] prev_data [N_CH];
  logic [SIZE_W-1:0] prev_size [N_CH];

  logic [ADDR_W-1:0] ch_addr [N_CH];
  logic [DATA_W-1:0] ch_data [N_CH];
  logic [SIZE_W-1:0] ch_size [N_CH];
  logic [ADDR_W-1:0] ch_off  [N_CH];
  logic [IDX_W-1:0]  ch_idx  [N_CH];
  logic [DATA_W-1:0] ch_mask [N_CH];
  logic [N_CH-1:0]   hit;
  logic [N_CH-1:0]   done;
  logic [N_CH-1:0]   changed;

  // Low 'size' bits set; any size at or above DATA_W selects the whole word.
  function automatic logic [DATA_W-1:0] size_mask(input logic [SIZE_W-1:0] sz);
    logic [DATA_W-1:0] m;
    if (32'(sz) >= DATA_W) m = '1;
    else                   m = ~({DATA_W{1'b1}} << sz);
    return m;
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign ch_addr[i] = addr[i*ADDR_W +: ADDR_W];
    assign ch_data[i] = wdata[i*DATA_W +: DATA_W];
    assign ch_size[i] = size[i*SIZE_W +: SIZE_W];
    assign ch_off[i]  = ch_addr[i] - base_addr;
    assign ch_idx[i]  = ch_off[i][IDX_W-1:0];
    assign ch_mask[i] = size_mask(ch_size[i]);

    // Only exactly one of oe/we inside the window is served.
    assign hit[i] = (oe[i] ^ we[i]) && (ch_addr[i] >= base_addr) &&
                    (32'(ch_off[i]) < MEM_WORDS);

    // Reset gates the handshake so nothing answers or commits while it is held.
    assign done[i] = hit[i] && reset && (cnt[i] >= (oe[i] ? RD_LAST : WR_LAST));

    assign changed[i] = (ch_addr[i] != prev_addr[i]) || (ch_data[i] != prev_data[i]) ||
                        (ch_size[i] != prev_size[i]);

    assign rdy[i] = done[i];
    assign rdata[i*DATA_W +: DATA_W] = (done[i] && oe[i]) ? (mem[ch_idx[i]] & ch_mask[i]) : '0;
  end

  // Latency counters, request history for change detection, sticky errors.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i]       <= '0;
        prev_addr[i] <= '0;
        prev_data[i] <= '0;
        prev_size[i] <= '0;
      end
      err <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        prev_addr[i] <= ch_addr[i];
        prev_data[i] <= ch_data[i];
        prev_size[i] <= ch_size[i];
        if (!hit[i] || done[i]) cnt[i] <= '0;
        else                    cnt[i] <= cnt[i] + CNT_W'(1);
        if ((oe[i] && we[i]) || (hit[i] && (cnt[i] != '0) && changed[i])) err[i] <= 1'b1;
      end
    end
  end

  // Storage is never cleared; later assignments win, so the highest channel then preload take priority.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_CH; i++) begin
      if (done[i] && we[i])
        mem[ch_idx[i]] <= (ch_data[i] & ch_mask[i]) | (mem[ch_idx[i]] & ~ch_mask[i]);
    end
    if (load_en && (32'(load_addr) < MEM_WORDS)) mem[load_addr[IDX_W-1:0]] <= load_data;
  end

endmodule

// File: tb/tb_bambu_offchip_mem_slave.sv
// Scoreboard bench for bambu_offchip_mem_slave: stimulus queues expected responses,
// a forked monitor pops and compares them whenever rdy is seen.
module tb_bambu_offchip_mem_slave;

  localparam int unsigned N_CH      = 2;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned SIZE_W    = 4;
  localparam int unsigned MEM_WORDS = 32;

  logic clock = 1'b0;
  logic reset;
  logic [ADDR_W-1:0]      base_addr;
  logic [N_CH-1:0]        oe, we, oe2, we2;
  logic [N_CH*ADDR_W-1:0] addr;
  logic [N_CH*DATA_W-1:0] wdata;
  logic [N_CH*SIZE_W-1:0] size;
  logic                   load_en;
  logic [ADDR_W-1:0]      load_addr;
  logic [DATA_W-1:0]      load_data;
  logic [N_CH*DATA_W-1:0] rdata, rdata2;
  logic [N_CH-1:0]        rdy, err, rdy2, err2;

  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          ch;
    int unsigned cycle;
    bit          is_rd;
    logic [7:0]  data;
  } rsp_t;
  rsp_t sbq[$];

  bambu_offchip_mem_slave #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W),
    .MEM_WORDS(MEM_WORDS), .RD_LAT(2), .WR_LAT(1)
  ) u_dut (
    .clock(clock), .reset(reset), .base_addr(base_addr), .oe(oe), .we(we),
    .addr(addr), .wdata(wdata), .size(size), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .rdata(rdata), .rdy(rdy), .err(err)
  );

  bambu_offchip_mem_slave #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W),
    .MEM_WORDS(MEM_WORDS), .RD_LAT(2), .WR_LAT(3)
  ) u_dut_w3 (
    .clock(clock), .reset(reset), .base_addr(base_addr), .oe(oe2), .we(we2),
    .addr(addr), .wdata(wdata), .size(size), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .rdata(rdata2), .rdy(rdy2), .err(err2)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clock);
      if (reset === 1'b1) begin
        for (int c = 0; c < int'(N_CH); c++) begin
          if (rdy[c]) begin
            int idx;
            rsp_t e;
            idx = -1;
            for (int k = 0; k < sbq.size(); k++) begin
              if (sbq[k].ch == c) begin
                idx = k;
                break;
              end
            end
            if (idx < 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_rdy ch%0d: got rdy=1, expected 0 (cycle %0d)", c, cyc);
            end else begin
              e = sbq[idx];
              sbq.delete(idx);
              check($sformatf("rdy_cycle_ch%0d", c), cyc, e.cycle);
              if (e.is_rd) check($sformatf("rdata_ch%0d", c), 32'(rdata[c*DATA_W +: DATA_W]), 32'(e.data));
            end
          end
        end
      end
    end
  endtask

  task automatic drive(input int ch, input bit r, input bit w, input logic [6:0] a,
                       input logic [7:0] d, input logic [3:0] sz);
    oe[ch] = r;
    we[ch] = w;
    addr[ch*ADDR_W +: ADDR_W]  = a;
    wdata[ch*DATA_W +: DATA_W] = d;
    size[ch*SIZE_W +: SIZE_W]  = sz;
  endtask

  task automatic idle(input int ch);
    oe[ch] = 1'b0;
    we[ch] = 1'b0;
  endtask

  task automatic expect_rsp(input int ch, input int unsigned lat, input bit is_rd, input logic [7:0] d);
    rsp_t e;
    e.ch = ch; e.cycle = cyc + lat - 1; e.is_rd = is_rd; e.data = d;
    sbq.push_back(e);
  endtask

  task automatic wait_rdy(input int ch);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!rdy[ch] && n < 32);
    if (!rdy[ch]) begin
      n_checks++;
      n_fail++;
      $display("FAIL rdy_timeout ch%0d: got no rdy, expected rdy within 32 cycles", ch);
    end
  endtask

  task automatic rd(input int ch, input logic [6:0] a, input logic [3:0] sz, input logic [7:0] exp);
    @(posedge clock); #1;
    drive(ch, 1'b1, 1'b0, a, 8'h00, sz);
    expect_rsp(ch, 2, 1'b1, exp);
    wait_rdy(ch);
    @(posedge clock); #1;
    idle(ch);
  endtask

  task automatic wr(input int ch, input logic [6:0] a, input logic [7:0] d, input logic [3:0] sz);
    @(posedge clock); #1;
    drive(ch, 1'b0, 1'b1, a, d, sz);
    expect_rsp(ch, 1, 1'b0, 8'h00);
    wait_rdy(ch);
    @(posedge clock); #1;
    idle(ch);
  endtask

  task automatic load(input logic [6:0] a, input logic [7:0] d);
    @(posedge clock); #1;
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clock); #1;
    load_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0; oe = '0; we = '0; oe2 = '0; we2 = '0;
    addr = '0; wdata = '0; size = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0; base_addr = 7'h10;
    fork monitor(); join_none

    repeat (2) @(negedge clock);
    check("reset_rdy", 32'(rdy), 32'h0);
    check("reset_rdata", 32'(rdata), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Preloads, including one just past the last word that must be dropped.
    load(7'd3, 8'hA5);
    load(7'd0, 8'h01);
    load(7'd31, 8'h5C);
    load(7'd32, 8'hEE);

    // Read, held one extra cycle: rdy must drop as the counter restarts.
    @(posedge clock); #1;
    drive(0, 1'b1, 1'b0, 7'h13, 8'h00, 4'd8);
    expect_rsp(0, 2, 1'b1, 8'hA5);
    wait_rdy(0);
    @(negedge clock);
    check("rdy_low_cycle2", 32'(rdy[0]), 32'h0);
    @(posedge clock); #1;
    idle(0);

    // Masked write then read-backs at several sizes.
    wr(1, 7'h13, 8'hFF, 4'd4);
    rd(0, 7'h13, 4'd8, 8'hAF);
    rd(1, 7'h13, 4'd4, 8'h0F);
    rd(0, 7'h13, 4'd0, 8'h00);
    wr(0, 7'h13, 8'hFF, 4'd0);
    rd(0, 7'h13, 4'd15, 8'hAF);

    // Window edges and the dropped out-of-range preload.
    rd(1, 7'h10, 4'd8, 8'h01);
    rd(0, 7'h2F, 4'd8, 8'h5C);

    // Same-edge collision, then the same collision against a preload.
    @(posedge clock); #1;
    drive(0, 1'b0, 1'b1, 7'h14, 8'h11, 4'd8);
    drive(1, 1'b0, 1'b1, 7'h14, 8'h22, 4'd8);
    expect_rsp(0, 1, 1'b0, 8'h00);
    expect_rsp(1, 1, 1'b0, 8'h00);
    wait_rdy(1);
    @(posedge clock); #1;
    idle(0); idle(1);
    rd(0, 7'h14, 4'd8, 8'h22);
    @(posedge clock); #1;
    drive(0, 1'b0, 1'b1, 7'h14, 8'h11, 4'd8);
    drive(1, 1'b0, 1'b1, 7'h14, 8'h22, 4'd8);
    load_en = 1'b1; load_addr = 7'd4; load_data = 8'h33;
    expect_rsp(0, 1, 1'b0, 8'h00);
    expect_rsp(1, 1, 1'b0, 8'h00);
    wait_rdy(1);
    @(posedge clock); #1;
    idle(0); idle(1); load_en = 1'b0;
    rd(1, 7'h14, 4'd8, 8'h33);

    // Overlap: ch1 write completes while ch0 read is in flight.
    @(posedge clock); #1;
    drive(0, 1'b1, 1'b0, 7'h13, 8'h00, 4'd8);
    drive(1, 1'b0, 1'b1, 7'h15, 8'h6B, 4'd8);
    expect_rsp(0, 2, 1'b1, 8'hAF);
    expect_rsp(1, 1, 1'b0, 8'h00);
    wait_rdy(1);
    @(posedge clock); #1;
    idle(1);
    wait_rdy(0);
    @(posedge clock); #1;
    idle(0);
    rd(0, 7'h15, 4'd8, 8'h6B);

    // Out of window above and below: the monitor flags any rdy.
    @(posedge clock); #1;
    drive(0, 1'b1, 1'b0, 7'h30, 8'h00, 4'd8);
    repeat (20) @(negedge clock);
    check("oow_rdy", 32'(rdy[0]), 32'h0);
    check("oow_rdata", 32'(rdata), 32'h0);
    check("oow_err", 32'(err), 32'h0);
    drive(0, 1'b1, 1'b0, 7'h0F, 8'h00, 4'd8);
    repeat (5) @(negedge clock);
    check("below_rdata", 32'(rdata), 32'h0);
    @(posedge clock); #1;
    idle(0);

    // Protocol errors.
    @(posedge clock); #1;
    drive(0, 1'b1, 1'b1, 7'h13, 8'h00, 4'd8);
    @(posedge clock); #1;
    idle(0);
    @(negedge clock);
    check("err_both_oe_we", 32'(err), 32'h1);
    @(posedge clock); #1;
    drive(1, 1'b1, 1'b0, 7'h13, 8'h00, 4'd8);
    @(posedge clock); #1;
    addr[ADDR_W +: ADDR_W] = 7'h14;
    expect_rsp(1, 1, 1'b1, 8'h33);
    wait_rdy(1);
    @(posedge clock); #1;
    idle(1);
    @(negedge clock);
    check("err_addr_change", 32'(err), 32'h3);
    repeat (5) @(negedge clock);
    check("err_sticky", 32'(err), 32'h3);

    // Reset in the middle of a WR_LAT=3 write on the second instance.
    @(posedge clock); #1;
    we2 = 2'b01;
    addr[0 +: ADDR_W] = 7'h13; wdata[0 +: DATA_W] = 8'h77; size[0 +: SIZE_W] = 4'd8;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("rst_mid_rdy2", 32'(rdy2), 32'h0);
    check("rst_mid_rdata2", 32'(rdata2), 32'h0);
    check("rst_mid_err", 32'(err), 32'h0);
    we2 = 2'b00;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    check("rst_err2", 32'(err2), 32'h0);
    @(posedge clock); #1;
    oe2 = 2'b01;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (!rdy2[0] && n < 32);
      check("rst_no_commit_rdy2", 32'(rdy2[0]), 32'h1);
      check("rst_no_commit_data", 32'(rdata2[0 +: DATA_W]), 32'hA5);
      check("rst_no_commit_lat", 32'(n), 32'd2);
    end
    @(posedge clock); #1;
    oe2 = 2'b00;
    repeat (3) @(posedge clock);

    check("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
